shift_chain_ctrl: RTL and testbench

//  Sequencer for a DEPTH-stage single-bit register chain (the x->y->z pipeline, nonblocking-correct).

---
 rtl/shift_chain_pkg.sv | 5 +
 rtl/shift_chain_if.sv | 26 ++
 rtl/shift_chain_core.sv | 21 ++
 rtl/shift_chain_ctrl.sv | 57 +++++
 tb/tb_shift_chain_ctrl.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/shift_chain_pkg.sv
// shift_chain_pkg: shared state encoding and widths for the shift chain sequencer
package shift_chain_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;
  localparam int OUT_CNT_W = 16;
endpackage

// File: rtl/shift_chain_if.sv
// shift_chain_if: source/sink handshake bundle for shift_chain_ctrl (out_cnt present when OUT_CNT_EN is defined)
interface shift_chain_if import shift_chain_pkg::*; #(parameter int DEPTH = 3);
  localparam int OCC_W = $clog2(DEPTH + 1);
  logic in_valid;
  logic in_bit;
  logic in_ready;
  logic flush;
  logic out_valid;
  logic out_bit;
  logic out_ready;
  logic [DEPTH-1:0] stage_q;
  logic [OCC_W-1:0] occupancy;
  logic busy;
`ifdef OUT_CNT_EN
  logic [OUT_CNT_W-1:0] out_cnt;
  modport master (output in_valid, in_bit, flush, out_ready,
                  input in_ready, out_valid, out_bit, stage_q, occupancy, busy, out_cnt);
  modport slave (input in_valid, in_bit, flush, out_ready,
                 output in_ready, out_valid, out_bit, stage_q, occupancy, busy, out_cnt);
`else
  modport master (output in_valid, in_bit, flush, out_ready,
                  input in_ready, out_valid, out_bit, stage_q, occupancy, busy);
  modport slave (input in_valid, in_bit, flush, out_ready,
                 output in_ready, out_valid, out_bit, stage_q, occupancy, busy);
`endif
endinterface

// File: rtl/shift_chain_core.sv
// shift_chain_core: DEPTH-stage data+valid register chain that shifts toward the tail on adv
module shift_chain_core #(parameter int DEPTH = 3) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             head_bit,
  input  logic             head_vld,
  output logic [DEPTH-1:0] data,
  output logic [DEPTH-1:0] vld
);
  // shift every stage one place tailward on advance, otherwise hold
  always_ff @(posedge clk) begin
    if (!rst) begin
      data <= '0;
      vld  <= '0;
    end else if (adv) begin
      data <= {data[DEPTH-2:0], head_bit};
      vld  <= {vld[DEPTH-2:0], head_vld};
    end
  end
endmodule

// File: rtl/shift_chain_ctrl.sv
// shift_chain_ctrl: valid/ready sequencer around a bit shift chain with flush drain (out_cnt when OUT_CNT_EN is defined)
module shift_chain_ctrl import shift_chain_pkg::*; #(parameter int DEPTH = 3) (
  input  logic clk,
  input  logic rst,
  shift_chain_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  state_t state, nxt;
  logic [DEPTH-1:0] data, vld;
  logic [OCC_W-1:0] occ, occ_nxt;
  logic draining, stall, adv, acc;
  assign draining = state == DRAIN;
  assign stall = vld[DEPTH-1] & ~bus.out_ready;
  assign adv = ~stall & (bus.in_valid | draining);
  assign bus.in_ready = rst & ~stall & ~draining;
  assign acc = bus.in_valid & bus.in_ready;
  assign bus.out_valid = vld[DEPTH-1] & (bus.in_valid | draining);
  assign bus.out_bit = data[DEPTH-1];
  assign bus.stage_q = data;
  assign bus.occupancy = occ;
  assign bus.busy = state != IDLE;
  assign occ_nxt = adv ? occ + OCC_W'(!draining) - OCC_W'(vld[DEPTH-1]) : occ;
  shift_chain_core #(.DEPTH(DEPTH)) u_core (
    .clk(clk), .rst(rst), .adv(adv),
    .head_bit(bus.in_bit & ~draining), .head_vld(~draining),
    .data(data), .vld(vld)
  );
  // state and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      occ   <= '0;
    end else begin
      state <= nxt;
      occ   <= occ_nxt;
    end
  end
  // an accepted bit coinciding with flush still enters and is drained with the rest
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = acc ? (bus.flush ? DRAIN : FILL) : IDLE;
      FILL:    nxt = bus.flush ? DRAIN : (occ_nxt == OCC_W'(DEPTH) ? RUN : FILL);
      RUN:     nxt = bus.flush ? DRAIN : (occ_nxt < OCC_W'(DEPTH) ? FILL : RUN);
      default: nxt = occ_nxt == '0 ? IDLE : DRAIN;
    endcase
  end
`ifdef OUT_CNT_EN
  logic [OUT_CNT_W-1:0] cnt;
  // free-running count of completed output transfers, only reset clears it
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else if (bus.out_valid & bus.out_ready) cnt <= cnt + 1'b1;
  end
  assign bus.out_cnt = cnt;
`endif
endmodule

// File: tb/tb_shift_chain_ctrl.sv
// tb_shift_chain_ctrl: directed self-checking bench for shift_chain_ctrl at DEPTH=3
module tb_shift_chain_ctrl;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  shift_chain_if #(.DEPTH(3)) bus();
  shift_chain_ctrl #(.DEPTH(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic b, input logic f, input logic r);
    bus.in_valid = v;
    bus.in_bit = b;
    bus.flush = f;
    bus.out_ready = r;
    #1;
  endtask
  initial begin
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rst_stage", 32'(bus.stage_q), 0);
      chk("rst_occ", 32'(bus.occupancy), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_ovalid", 32'(bus.out_valid), 0);
      chk("rst_iready", 32'(bus.in_ready), 0);
    end
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("fill_iready", 32'(bus.in_ready), 1);
    tick;
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    tick;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    tick;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("full_stage", 32'(bus.stage_q), 32'b101);
    chk("full_occ", 32'(bus.occupancy), 3);
    chk("full_state", 32'(dut.state), 2);
    chk("full_ovalid", 32'(bus.out_valid), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk("push4_ovalid", 32'(bus.out_valid), 1);
    chk("push4_obit", 32'(bus.out_bit), 1);
    tick;
    chk("push4_stage", 32'(bus.stage_q), 32'b010);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_iready", 32'(bus.in_ready), 0);
      tick;
      chk("stall_stage", 32'(bus.stage_q), 32'b010);
      chk("stall_occ", 32'(bus.occupancy), 3);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("unstall_ovalid", 32'(bus.out_valid), 1);
    chk("unstall_obit", 32'(bus.out_bit), 0);
    tick;
    chk("unstall_stage", 32'(bus.stage_q), 32'b101);
    chk("unstall_occ", 32'(bus.occupancy), 3);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick;
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    tick;
    tick;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("two_stage", 32'(bus.stage_q), 32'b011);
    chk("two_occ", 32'(bus.occupancy), 2);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    tick;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("flush_state", 32'(dut.state), 3);
    chk("flush_iready", 32'(bus.in_ready), 0);
    chk("drain1_ovalid", 32'(bus.out_valid), 0);
    tick;
    chk("drain1_stage", 32'(bus.stage_q), 32'b110);
    chk("drain2_ovalid", 32'(bus.out_valid), 1);
    chk("drain2_obit", 32'(bus.out_bit), 1);
    tick;
    chk("drain2_occ", 32'(bus.occupancy), 1);
    chk("drain3_ovalid", 32'(bus.out_valid), 1);
    chk("drain3_obit", 32'(bus.out_bit), 1);
    tick;
    chk("drained_occ", 32'(bus.occupancy), 0);
    chk("drained_busy", 32'(bus.busy), 0);
    chk("drained_stage", 32'(bus.stage_q), 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    tick;
    chk("idle_flush_busy", 32'(bus.busy), 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    chk("fin_iready", 32'(bus.in_ready), 1);
    tick;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("fin_state", 32'(dut.state), 3);
    chk("fin_occ", 32'(bus.occupancy), 1);
    chk("fin_stage", 32'(bus.stage_q), 32'b001);
    for (int i = 0; i < 2; i++) begin
      chk("fin_wait_ovalid", 32'(bus.out_valid), 0);
      tick;
    end
    chk("fin_ovalid", 32'(bus.out_valid), 1);
    chk("fin_obit", 32'(bus.out_bit), 1);
    tick;
    chk("fin_busy", 32'(bus.busy), 0);
    chk("fin_occ0", 32'(bus.occupancy), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    tick;
    tick;
    tick;
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    tick;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick;
    chk("middrain_state", 32'(dut.state), 3);
    rst = 1'b0;
    tick;
    chk("middrain_stage", 32'(bus.stage_q), 0);
    chk("middrain_occ", 32'(bus.occupancy), 0);
    chk("middrain_busy", 32'(bus.busy), 0);
    chk("middrain_ovalid", 32'(bus.out_valid), 0);
    chk("middrain_iready", 32'(bus.in_ready), 0);
`ifdef OUT_CNT_EN
    chk("cnt_rst", 32'(bus.out_cnt), 0);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    begin
      int n = 0;
      int cyc = 0;
      while (n < 65537 && cyc < 70000) begin
        if (bus.out_valid && bus.out_ready) n++;
        tick;
        cyc++;
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("cnt_xfers", 32'(n), 65537);
      chk("cnt_wrap", 32'(bus.out_cnt), 1);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
